keccak_squeeze_unit: RTL and testbench
======================================

Name: keccak_squeeze_unit

Overview:
Sequential output-side counterpart of the absorb datapath: reads the rate portion of the Keccak state and streams it as DWIDTH-bit beats with byte keep, valid/ready handshake. It sits between the permutation core and the digest/XOF output port. It counts squeezed bytes, requests a new permutation when the rate is exhausted, and terminates after the requested output length.

Parameters:
OUT_LEN_WIDTH, 16, width of requested output byte count.
DWIDTH, keccak_pkg::DWIDTH (256), output beat width in bits.
KEEP_WIDTH, DWIDTH/8 (32), byte-enable width.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
start_i  in  1  one-cycle request to begin squeezing; sampled only in IDLE.
out_len_i  in  OUT_LEN_WIDTH  total bytes to emit; latched on start_i.
rate_i  in  RATE_WIDTH  rate in bits (576/1088/1344 etc.); latched on start_i.
state_array_i  in  [ROW_SIZE][COL_SIZE][LANE_SIZE]  Keccak state; engine holds it stable outside PERM_WAIT.
perm_done_i  in  1  one-cycle pulse: permutation finished, state_array_i updated.
data_o  out  DWIDTH  output beat; byte 0 at bits [7:0].
keep_o  out  KEEP_WIDTH  valid bytes, contiguous from bit 0.
valid_o  out  1  beat valid.
ready_i  in  1  downstream accepts beat.
last_o  out  1  final beat of request.
perm_req_o  out  1  one-cycle pulse requesting a permutation.
busy_o  out  1  high in any state except IDLE.
done_o  out  1  one-cycle pulse after final beat accepted.

Behaviour:
- Reset: state IDLE; valid_o, last_o, perm_req_o, busy_o, done_o = 0; data_o, keep_o = 0; counters cleared. Reset mid-operation abandons request silently.
- Byte map: state byte b (0..rate/8-1) = lane i=b/8, x=i%5, y=i/5, bits [8*(b%8)+:8] of state_array_i[x][y].
- FSM IDLE -> EMIT -> (PERM_WAIT -> EMIT)* -> IDLE.
- IDLE: start_i with out_len_i != 0 latches len/rate, pos=0, enters EMIT next cycle. start_i with out_len_i == 0: done_o pulses next cycle, no beats. start_i outside IDLE ignored.
- EMIT: valid_o=1. n = min(32, rate/8 - pos, remaining). data_o = state bytes pos..pos+n-1 in bytes 0..n-1, upper bytes zero; keep_o = (1<<n)-1; last_o = (n == remaining). data/keep/last stable while valid_o && !ready_i.
- On valid_o && ready_i: remaining -= n, pos += n. remaining==0 -> IDLE, done_o pulses the following cycle. Else pos==rate/8 -> PERM_WAIT, pos=0, perm_req_o pulses that cycle.
- PERM_WAIT: valid_o=0; perm_done_i ignored in the same cycle perm_req_o is high; on later perm_done_i -> EMIT next cycle.
- Throughput: one beat per cycle while ready_i high; no bubble between beats inside one block.
- Output beats zero-data when valid_o=0.

Optional Feature:
SQUEEZE_PACK_EN. Defined: beat that would be short at a block boundary (rate/8 - pos < 32, remaining > rate/8 - pos) is not emitted; tail bytes latched into a 32-byte carry register, permutation requested, and after perm_done_i the next beat = carry bytes followed by head bytes of the new block (pos restarts at 32 - tail); every beat except last is full 32 bytes. Undefined: no carry register; short beats at block boundaries are emitted with partial keep_o as above.

Test Plan:
- Lane i = {8{8'(i+1)}}, rate 1088, len 32, ready=1 -> one beat, data = lanes 3..0, keep=32'hFFFFFFFF, last=1, done_o next cycle, perm_req_o never.
- Same state, len 5 -> one beat data=40'h0101010101, keep=32'h1F, last=1.
- rate 1088, len 200, pack off -> beats keep FFFFFFFF x4, 000000FF (lane16, perm_req_o pulse on accept), after perm_done_i FFFFFFFF, FFFFFFFF(last); 1 permutation.
- Same with SQUEEZE_PACK_EN -> beats 32,32,32,32,32,32,8(last): 5th beat = old lane16 + new lanes 0..2; final keep 32'hFF.
- rate 576, len 72, ready toggling 1/0 -> data held during stalls, beats 32,32,8, last on third, no perm_req_o.
- rst asserted mid-EMIT, then start_i len 32 -> outputs zero immediately, new request completes normally; start_i while busy ignored.

Source files
------------

// File: rtl/keccak_squeeze_unit.sv
`default_nettype none
// ============================================================================
// keccak_squeeze_unit: streams the rate part of the Keccak state as byte-kept
// beats and requests permutations between blocks. Define SQUEEZE_PACK_EN to
// carry block-boundary tails into the next beat.  Revision: 1.0
// ============================================================================
module keccak_squeeze_unit #(
    parameter int OUT_LEN_WIDTH = 16,
    parameter int DWIDTH        = 256,
    parameter int KEEP_WIDTH    = DWIDTH / 8,
    parameter int RATE_WIDTH    = 11,
    parameter int ROW_SIZE      = 5,
    parameter int COL_SIZE      = 5,
    parameter int LANE_SIZE     = 64
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             start_i,
    input  logic [OUT_LEN_WIDTH-1:0]                         out_len_i,
    input  logic [RATE_WIDTH-1:0]                            rate_i,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
    input  logic                                             perm_done_i,
    output logic [DWIDTH-1:0]                                data_o,
    output logic [KEEP_WIDTH-1:0]                            keep_o,
    output logic                                             valid_o,
    input  logic                                             ready_i,
    output logic                                             last_o,
    output logic                                             perm_req_o,
    output logic                                             busy_o,
    output logic                                             done_o
);
    localparam int STATE_BYTES = ROW_SIZE * COL_SIZE * LANE_SIZE / 8;
    localparam int IDX_W       = $clog2(STATE_BYTES);
    localparam int POS_W       = RATE_WIDTH - 3;
    localparam int CNT_W       = $clog2(KEEP_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EMIT      = 2'd1,
        PERM_WAIT = 2'd2
    } state_t;

    state_t                   fsm;
    logic [POS_W-1:0]         pos;
    logic [OUT_LEN_WIDTH-1:0] remaining;
    logic [RATE_WIDTH-1:0]    rate_bits;
    logic [CNT_W-1:0]         ccnt;

    logic [7:0]               state_bytes [STATE_BYTES];
    logic [DWIDTH-1:0]        beat_data;
    logic [KEEP_WIDTH-1:0]    beat_keep;
    int                       rate_bytes, avail, nbytes, new_pos, new_rem, next_avail, src;

    // Lane i lives at x = i % 5, y = i / 5; byte b is lane b/8, little-endian.
    for (genvar b = 0; b < STATE_BYTES; b++) begin : g_bytes
        localparam int LANE = b / 8;
        assign state_bytes[b] = state_array_i[LANE % ROW_SIZE][LANE / ROW_SIZE][8*(b%8) +: 8];
    end

`ifdef SQUEEZE_PACK_EN
    logic [KEEP_WIDTH-1:0][7:0] carry, carry_next;
    int                         csrc;

    always_comb begin
        carry_next = '0;
        csrc       = 0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            csrc = new_pos + k;
            if (k < next_avail && csrc >= 0 && csrc < STATE_BYTES)
                carry_next[k] = state_bytes[csrc[IDX_W-1:0]];
        end
    end
`else
    assign ccnt = '0;
`endif

    // ccnt carried bytes lead the beat; block bytes follow from pos.
    always_comb begin
        rate_bytes = int'(rate_bits >> 3);
        avail      = rate_bytes - int'(pos) + int'(ccnt);
        nbytes     = KEEP_WIDTH;
        if (avail < nbytes) nbytes = avail;
        if (int'(remaining) < nbytes) nbytes = int'(remaining);
        new_pos    = int'(pos) + nbytes - int'(ccnt);
        new_rem    = int'(remaining) - nbytes;
        next_avail = rate_bytes - new_pos;
        beat_data  = '0;
        beat_keep  = '0;
        src        = 0;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            if (k < nbytes) begin
                beat_keep[k] = 1'b1;
                src = int'(pos) + k - int'(ccnt);
                if (src >= 0 && src < STATE_BYTES)
                    beat_data[8*k +: 8] = state_bytes[src[IDX_W-1:0]];
`ifdef SQUEEZE_PACK_EN
                if (k < int'(ccnt))
                    beat_data[8*k +: 8] = carry[k];
`endif
            end
        end
    end

    assign data_o = valid_o ? beat_data : '0;
    assign keep_o = valid_o ? beat_keep : '0;
    assign last_o = valid_o && (nbytes == int'(remaining));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= IDLE;
            valid_o    <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            perm_req_o <= 1'b0;
            pos        <= '0;
            remaining  <= '0;
            rate_bits  <= '0;
`ifdef SQUEEZE_PACK_EN
            carry      <= '0;
            ccnt       <= '0;
`endif
        end else begin
            done_o     <= 1'b0;
            perm_req_o <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        if (out_len_i == '0) begin
                            done_o <= 1'b1;
                        end else begin
                            remaining <= out_len_i;
                            rate_bits <= rate_i;
                            pos       <= '0;
`ifdef SQUEEZE_PACK_EN
                            ccnt      <= '0;
`endif
                            fsm       <= EMIT;
                            valid_o   <= 1'b1;
                            busy_o    <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (ready_i) begin
                        pos       <= new_pos[POS_W-1:0];
                        remaining <= new_rem[OUT_LEN_WIDTH-1:0];
`ifdef SQUEEZE_PACK_EN
                        ccnt      <= '0;
`endif
                        if (new_rem == 0) begin
                            fsm     <= IDLE;
                            valid_o <= 1'b0;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end else if (next_avail == 0) begin
                            fsm        <= PERM_WAIT;
                            pos        <= '0;
                            valid_o    <= 1'b0;
                            perm_req_o <= 1'b1;
                        end
`ifdef SQUEEZE_PACK_EN
                        // Short tail at block end: park it and emit it with the next block.
                        else if (next_avail < KEEP_WIDTH && new_rem > next_avail) begin
                            fsm        <= PERM_WAIT;
                            pos        <= '0;
                            valid_o    <= 1'b0;
                            perm_req_o <= 1'b1;
                            carry      <= carry_next;
                            ccnt       <= next_avail[CNT_W-1:0];
                        end
`endif
                    end
                end
                PERM_WAIT: begin
                    if (perm_done_i && !perm_req_o) begin
                        fsm     <= EMIT;
                        valid_o <= 1'b1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_keccak_squeeze_unit.sv
`default_nettype none
// ============================================================================
// tb_keccak_squeeze_unit: directed stimulus with hand-computed beats.
// Revision: 1.0
// ============================================================================
module tb_keccak_squeeze_unit;
    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start_i;
    logic [15:0]            out_len_i;
    logic [10:0]            rate_i;
    logic [4:0][4:0][63:0]  state_array_i;
    logic                   perm_done_i;
    logic [255:0]           data_o;
    logic [31:0]            keep_o;
    logic                   valid_o;
    logic                   ready_i;
    logic                   last_o;
    logic                   perm_req_o;
    logic                   busy_o;
    logic                   done_o;

    int checks = 0;
    int errors = 0;
    int perm_count = 0;
    int p0;

    keccak_squeeze_unit dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .out_len_i     (out_len_i),
        .rate_i        (rate_i),
        .state_array_i (state_array_i),
        .perm_done_i   (perm_done_i),
        .data_o        (data_o),
        .keep_o        (keep_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .last_o        (last_o),
        .perm_req_o    (perm_req_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (perm_req_o) perm_count <= perm_count + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ln(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_lanes(input logic [7:0] base);
        for (int i = 0; i < 25; i++)
            state_array_i[i % 5][i / 5] = ln(8'(i) + base);
    endtask

    task automatic start(input logic [15:0] len, input logic [10:0] rate);
        start_i   = 1'b1;
        out_len_i = len;
        rate_i    = rate;
        step();
        start_i   = 1'b0;
    endtask

    // Waits up to wait_max cycles for valid, checks the beat, lets it be accepted.
    task automatic expect_beat(input string tag, input int wait_max, input logic [255:0] d,
                               input logic [31:0] k, input logic l);
        int n = 0;
        while (!valid_o && n < wait_max) begin
            step();
            n++;
        end
        check1({tag, " valid"}, valid_o, 1'b1);
        checkw({tag, " data"}, data_o, d);
        checkk({tag, " keep"}, keep_o, k);
        check1({tag, " last"}, last_o, l);
        step();
    endtask

    task automatic stall_beat(input string tag, input logic [255:0] d, input logic [31:0] k,
                              input logic l);
        ready_i = 1'b0;
        check1({tag, " valid"}, valid_o, 1'b1);
        checkw({tag, " data"}, data_o, d);
        checkk({tag, " keep"}, keep_o, k);
        check1({tag, " last"}, last_o, l);
        step();
        check1({tag, " held valid"}, valid_o, 1'b1);
        checkw({tag, " held data"}, data_o, d);
        checkk({tag, " held keep"}, keep_o, k);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; perm_done_i = 1'b0; ready_i = 1'b1;
        out_len_i = '0; rate_i = '0;
        set_lanes(8'h01);
        repeat (2) step();
        check1("rst valid", valid_o, 1'b0);
        check1("rst busy", busy_o, 1'b0);
        check1("rst done", done_o, 1'b0);
        check1("rst perm_req", perm_req_o, 1'b0);
        check1("rst last", last_o, 1'b0);
        checkw("rst data", data_o, '0);
        checkk("rst keep", keep_o, '0);
        rst = 1'b0;
        step();

        // Single full beat
        p0 = perm_count;
        start(16'd32, 11'd1088);
        expect_beat("t1", 0, {ln(8'h04), ln(8'h03), ln(8'h02), ln(8'h01)}, 32'hFFFFFFFF, 1'b1);
        check1("t1 done", done_o, 1'b1);
        check1("t1 busy", busy_o, 1'b0);
        step();
        check1("t1 done pulse", done_o, 1'b0);
        checkw("t1 perms", 256'(perm_count - p0), 256'(0));

        // Short single beat
        start(16'd5, 11'd1088);
        expect_beat("t2", 0, 256'h0101010101, 32'h0000001F, 1'b1);
        check1("t2 done", done_o, 1'b1);
        step();

        // Multi-block request, 200 bytes at rate 1088
        p0 = perm_count;
        start(16'd200, 11'd1088);
        expect_beat("t3 b1", 0, {ln(8'h04), ln(8'h03), ln(8'h02), ln(8'h01)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b2", 0, {ln(8'h08), ln(8'h07), ln(8'h06), ln(8'h05)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b3", 0, {ln(8'h0C), ln(8'h0B), ln(8'h0A), ln(8'h09)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b4", 0, {ln(8'h10), ln(8'h0F), ln(8'h0E), ln(8'h0D)}, 32'hFFFFFFFF, 1'b0);
`ifndef SQUEEZE_PACK_EN
        expect_beat("t3 b5", 0, 256'(ln(8'h11)), 32'h000000FF, 1'b0);
`endif
        check1("t3 perm_req", perm_req_o, 1'b1);
        check1("t3 wait valid", valid_o, 1'b0);
        perm_done_i = 1'b1;
        step();
        perm_done_i = 1'b0;
        check1("t3 early done ignored", valid_o, 1'b0);
        check1("t3 perm_req pulse", perm_req_o, 1'b0);
        set_lanes(8'h41);
        repeat (2) step();
        check1("t3 still waiting", valid_o, 1'b0);
        check1("t3 busy wait", busy_o, 1'b1);
        perm_done_i = 1'b1;
        step();
        perm_done_i = 1'b0;
`ifdef SQUEEZE_PACK_EN
        expect_beat("t3 b5", 0, {ln(8'h43), ln(8'h42), ln(8'h41), ln(8'h11)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b6", 0, {ln(8'h47), ln(8'h46), ln(8'h45), ln(8'h44)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b7", 0, 256'(ln(8'h48)), 32'h000000FF, 1'b1);
`else
        expect_beat("t3 b6", 0, {ln(8'h44), ln(8'h43), ln(8'h42), ln(8'h41)}, 32'hFFFFFFFF, 1'b0);
        expect_beat("t3 b7", 0, {ln(8'h48), ln(8'h47), ln(8'h46), ln(8'h45)}, 32'hFFFFFFFF, 1'b1);
`endif
        check1("t3 done", done_o, 1'b1);
        step();
        checkw("t3 perms", 256'(perm_count - p0), 256'(1));

        // Rate 576, exact block length, stalled downstream
        set_lanes(8'h01);
        p0 = perm_count;
        ready_i = 1'b0;
        start(16'd72, 11'd576);
        stall_beat("t4 b1", {ln(8'h04), ln(8'h03), ln(8'h02), ln(8'h01)}, 32'hFFFFFFFF, 1'b0);
        stall_beat("t4 b2", {ln(8'h08), ln(8'h07), ln(8'h06), ln(8'h05)}, 32'hFFFFFFFF, 1'b0);
        stall_beat("t4 b3", 256'(ln(8'h09)), 32'h000000FF, 1'b1);
        check1("t4 done", done_o, 1'b1);
        step();
        checkw("t4 perms", 256'(perm_count - p0), 256'(0));

        // Zero-length request
        start(16'd0, 11'd1088);
        check1("t5 done", done_o, 1'b1);
        check1("t5 valid", valid_o, 1'b0);
        check1("t5 busy", busy_o, 1'b0);
        step();
        check1("t5 done pulse", done_o, 1'b0);

        // Start ignored while busy, then asynchronous reset mid-EMIT
        ready_i = 1'b0;
        start(16'd200, 11'd1088);
        check1("t6 busy", busy_o, 1'b1);
        start(16'd5, 11'd1088);
        checkk("t6 ignored start keep", keep_o, 32'hFFFFFFFF);
        check1("t6 ignored start last", last_o, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check1("t6 rst valid", valid_o, 1'b0);
        check1("t6 rst busy", busy_o, 1'b0);
        checkw("t6 rst data", data_o, '0);
        checkk("t6 rst keep", keep_o, '0);
        step();
        rst = 1'b0;
        step();
        start(16'd32, 11'd1088);
        start(16'd5, 11'd1088);
        ready_i = 1'b1;
        expect_beat("t6 beat", 0, {ln(8'h04), ln(8'h03), ln(8'h02), ln(8'h01)}, 32'hFFFFFFFF, 1'b1);
        check1("t6 done", done_o, 1'b1);
        step();
        check1("t6 idle", busy_o, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
